// File: rtl/top_k_insert_sorter.sv
// Keeps the K nearest (distance, index) candidates of one query in a sorted insertion
// shift register and pulses top_k_done with the final list at end of stream.
module top_k_insert_sorter #(
    parameter int unsigned K      = 8,
    parameter int unsigned DIST_W = 16,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cand_valid,
    output logic                         cand_ready,
    input  logic [DIST_W-1:0]            cand_dist,
    input  logic [IDX_W-1:0]             cand_idx,
    input  logic                         cand_last,
    output logic [K-1:0][DIST_W-1:0]     top_k_dist,
    output logic [K-1:0][IDX_W-1:0]      top_k_idx,
    output logic [K-1:0]                 top_k_vld,
    output logic                         top_k_done,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   clear;
    logic   accept;

    logic [CNT_W-1:0]            pos;
    logic [K-1:0][DIST_W-1:0]    dist_nxt;
    logic [K-1:0][IDX_W-1:0]     idx_nxt;
    logic [K-1:0]                vld_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cand_ready = 1'b0;
        busy       = 1'b0;
        top_k_done = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                cand_ready = 1'b1;
                busy       = 1'b1;
                if (cand_valid && cand_last) state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                top_k_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = cand_valid & cand_ready;

    // Insert position: valid entries at or below the candidate stay ahead of it (stable ties).
    always_comb begin
        pos = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (top_k_vld[i] && (top_k_dist[i] <= cand_dist)) pos = pos + CNT_W'(1);
        end
    end

    // Slots past pos shift down by one; slot pos takes the candidate. pos == K leaves all as is.
    always_comb begin
        dist_nxt = top_k_dist;
        idx_nxt  = top_k_idx;
        vld_nxt  = top_k_vld;
        for (int unsigned i = 1; i < K; i++) begin
            if (CNT_W'(i) > pos) begin
                dist_nxt[i] = top_k_dist[i-1];
                idx_nxt[i]  = top_k_idx[i-1];
                vld_nxt[i]  = top_k_vld[i-1];
            end
        end
        for (int unsigned i = 0; i < K; i++) begin
            if (CNT_W'(i) == pos) begin
                dist_nxt[i] = cand_dist;
                idx_nxt[i]  = cand_idx;
                vld_nxt[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            top_k_dist <= '1;
            top_k_idx  <= '0;
            top_k_vld  <= '0;
        end else if (accept) begin
            top_k_dist <= dist_nxt;
            top_k_idx  <= idx_nxt;
            top_k_vld  <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_top_k_insert_sorter.sv
// Bench for top_k_insert_sorter (K=4): queue-based reference model checked every cycle,
// plus directed streams with hand-computed final lists.
module tb_top_k_insert_sorter;

    localparam int unsigned K      = 4;
    localparam int unsigned DIST_W = 16;
    localparam int unsigned IDX_W  = 16;

    typedef struct packed {
        logic [DIST_W-1:0] d;
        logic [IDX_W-1:0]  i;
    } ent_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic                      cand_valid = 1'b0;
    logic                      cand_ready;
    logic [DIST_W-1:0]         cand_dist = '0;
    logic [IDX_W-1:0]          cand_idx = '0;
    logic                      cand_last = 1'b0;
    logic [K-1:0][DIST_W-1:0]  top_k_dist;
    logic [K-1:0][IDX_W-1:0]   top_k_idx;
    logic [K-1:0]              top_k_vld;
    logic                      top_k_done;
    logic                      busy;

    int n_cmp = 0;
    int n_bad = 0;

    top_k_insert_sorter #(.K(K), .DIST_W(DIST_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_dist  (cand_dist),
        .cand_idx   (cand_idx),
        .cand_last  (cand_last),
        .top_k_dist (top_k_dist),
        .top_k_idx  (top_k_idx),
        .top_k_vld  (top_k_vld),
        .top_k_done (top_k_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 done; hist = every candidate accepted this query.
    int   m_phase = 0;
    bit   m_live  = 1'b0;
    ent_t hist[$];

    initial forever begin
        @(posedge clk);
        m_live = 1'b1;
        if (rst) begin
            m_phase = 0;
            hist.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    hist.delete();
                    m_phase = 1;
                end
                1: if (cand_valid) begin
                    hist.push_back('{d: cand_dist, i: cand_idx});
                    if (cand_last) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Expected list: repeatedly take the smallest distance, earliest arrival first.
    function automatic void model_list(output logic [K-1:0][DIST_W-1:0] ed,
                                       output logic [K-1:0][IDX_W-1:0] ei,
                                       output logic [K-1:0] ev);
        bit used[];
        used = new[hist.size()];
        for (int s = 0; s < int'(K); s++) begin
            int best = -1;
            for (int j = 0; j < hist.size(); j++) begin
                if (!used[j] && (best < 0 || hist[j].d < hist[best].d)) best = j;
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                ed[s] = hist[best].d;
                ei[s] = hist[best].i;
                ev[s] = 1'b1;
            end else begin
                ed[s] = '1;
                ei[s] = '0;
                ev[s] = 1'b0;
            end
        end
    endfunction

    initial forever begin
        logic [K-1:0][DIST_W-1:0] ed;
        logic [K-1:0][IDX_W-1:0]  ei;
        logic [K-1:0]             ev;
        @(negedge clk);
        if (m_live) begin
            model_list(ed, ei, ev);
            check("model_dist", 64'(top_k_dist), 64'(ed));
            check("model_idx", 64'(top_k_idx), 64'(ei));
            check("model_vld", 64'(top_k_vld), 64'(ev));
            check("model_ready", 64'(cand_ready), 64'(m_phase == 1));
            check("model_busy", 64'(busy), 64'(m_phase != 0));
            check("model_done", 64'(top_k_done), 64'(m_phase == 2));
        end
    end

    // All drivers run #1 after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DIST_W-1:0] d, input logic [IDX_W-1:0] i, input logic l);
        cand_valid = 1'b1;
        cand_dist  = d;
        cand_idx   = i;
        cand_last  = l;
        tick();
        cand_valid = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (top_k_done) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd1);
        tick();
    endtask

    task automatic check_list(input string name, input logic [63:0] d, input logic [63:0] i,
                              input logic [3:0] v);
        check({name, "_dist"}, 64'(top_k_dist), d);
        check({name, "_idx"}, 64'(top_k_idx), i);
        check({name, "_vld"}, 64'(top_k_vld), 64'(v));
    endtask

    initial begin
        #20000000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        @(negedge clk);
        check_list("reset", {4{16'hFFFF}}, 64'd0, 4'b0000);
        check("reset_ready", 64'(cand_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(top_k_done), 64'd0);
        rst = 1'b0;
        tick();

        // Basic sort: 50,10,40,30,20 -> 10,20,30,40 with idx 1,4,3,2; done right after last accept.
        do_start();
        send(16'd50, 16'd0, 1'b0);
        send(16'd10, 16'd1, 1'b0);
        send(16'd40, 16'd2, 1'b0);
        send(16'd30, 16'd3, 1'b0);
        send(16'd20, 16'd4, 1'b1);
        @(negedge clk);
        check("basic_done_latency", 64'(top_k_done), 64'd1);
        check_list("basic", {16'd40, 16'd30, 16'd20, 16'd10}, {16'd2, 16'd3, 16'd4, 16'd1}, 4'b1111);
        tick();

        // Ties keep arrival order; trailing slot stays empty.
        do_start();
        send(16'd5, 16'd0, 1'b0);
        send(16'd5, 16'd1, 1'b0);
        send(16'd5, 16'd2, 1'b1);
        wait_done("ties_done");
        check_list("ties", {16'hFFFF, 16'd5, 16'd5, 16'd5}, {16'd0, 16'd2, 16'd1, 16'd0}, 4'b0111);

        // Full list, then a larger last candidate is discarded.
        do_start();
        send(16'd1, 16'd10, 1'b0);
        send(16'd2, 16'd11, 1'b0);
        send(16'd3, 16'd12, 1'b0);
        send(16'd4, 16'd13, 1'b0);
        send(16'd9, 16'd14, 1'b1);
        @(negedge clk);
        check("full_done", 64'(top_k_done), 64'd1);
        check("full_ready_in_done", 64'(cand_ready), 64'd0);
        check_list("full", {16'd4, 16'd3, 16'd2, 16'd1}, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b1111);
        tick();

        // cand_valid in IDLE is ignored.
        cand_valid = 1'b1;
        cand_dist  = 16'd0;
        cand_idx   = 16'd99;
        cand_last  = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("idle_ready", 64'(cand_ready), 64'd0);
        check_list("idle_hold", {16'd4, 16'd3, 16'd2, 16'd1}, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b1111);
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        tick();

        // start during COLLECT does not clear.
        do_start();
        send(16'd6, 16'd0, 1'b0);
        do_start();
        send(16'd3, 16'd1, 1'b1);
        wait_done("nostart_done");
        check_list("nostart", {16'hFFFF, 16'hFFFF, 16'd6, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd1}, 4'b0011);

        // Reset mid-query aborts; a fresh query works afterwards.
        do_start();
        send(16'd11, 16'd0, 1'b0);
        send(16'd12, 16'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(top_k_done), 64'd0);
        check("abort_vld", 64'(top_k_vld), 64'd0);
        tick();
        do_start();
        send(16'd7, 16'd0, 1'b1);
        wait_done("fresh_done");
        check_list("fresh", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd7}, 64'd0, 4'b0001);

        // All-ones distance still fills a free slot.
        do_start();
        send(16'hFFFF, 16'd3, 1'b0);
        send(16'd2, 16'd4, 1'b1);
        wait_done("ones_done");
        check_list("ones", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd2}, {16'd0, 16'd0, 16'd3, 16'd4}, 4'b0011);

        // Random 64-candidate streams with gaps; the per-cycle model check covers them.
        for (int q = 0; q < 3; q++) begin
            do_start();
            for (int n = 0; n < 64; n++) begin
                logic [DIST_W-1:0] d;
                while ($urandom_range(0, 3) == 0) tick();
                d = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
                send(d, 16'(n), n == 63);
            end
            wait_done("rand_done");
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
